// File: rtl/vg8020_ram_pkg.sv
// Shared constants and FSM state type for the VG8020 slot-3 main RAM.
package vg8020_ram_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StClear
    } state_e;

endpackage

// File: rtl/vg8020_ram_array.sv
// Single-port byte array with synchronous write and registered, enabled read.
module vg8020_ram_array #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2 ** ADDR_W];

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/vg8020_ram.sv
// 64 KiB main RAM in primary slot 3: Z80 bus decode, access FSM, address latch, bus driver.
// Optional power-up wipe of the array when RAM_CLEAR_EN is defined.
module vg8020_ram
    import vg8020_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              nclk,
    input  logic              reset,
    input  logic              nmreq,
    input  logic              nmreqd,
    input  logic              nrdd,
    input  logic              nrfshd,
    input  logic              nsltsl3,
    input  logic [ADDR_W-1:0] addr,
    inout  logic [DATA_W-1:0] data
);

`ifdef RAM_CLEAR_EN
    localparam state_e RstState = StClear;
`else
    localparam state_e RstState = StIdle;
`endif

    state_e            state_q, state_d;
    logic              nmreq_q;
    logic              abort_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rd_q;
    logic              sel, rd_strobe, start, clearing;
    logic              we, re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign sel       = !nsltsl3 && !nmreqd && nrfshd;
    assign rd_strobe = sel && !nrdd;
    assign start     = nmreq_q && !nmreq;

`ifdef RAM_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt_q;

    always_ff @(posedge nclk) begin
        if (reset) begin
            clr_cnt_q <= '0;
        end else if (state_q == StClear) begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        end
    end

    assign clearing  = (state_q == StClear);
    assign mem_addr  = clearing ? clr_cnt_q : addr_q;
    assign mem_wdata = clearing ? '0 : data;
`else
    assign clearing  = 1'b0;
    assign mem_addr  = addr_q;
    assign mem_wdata = data;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            // abort_q keeps a cycle cut short by reset from restarting.
            StIdle:   if (sel && !abort_q) state_d = StAccess;
            StAccess: if (nmreqd || nsltsl3) state_d = StIdle;
`ifdef RAM_CLEAR_EN
            StClear:  if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = StIdle;
`endif
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge nclk) begin
        if (reset) begin
            state_q <= RstState;
            nmreq_q <= 1'b1;
            addr_q  <= '0;
            abort_q <= 1'b1;
        end else begin
            state_q <= state_d;
            nmreq_q <= nmreq;
            if (start) begin
                addr_q <= addr;
            end
            if (nmreqd) begin
                abort_q <= 1'b0;
            end
        end
    end

    assign we     = (state_q == StAccess) && sel && nrdd;
    assign re     = !reset && (state_q == StAccess) && rd_strobe;
    assign mem_we = !reset && (clearing || we);

    vg8020_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (nclk),
        .reset (reset),
        .we    (mem_we),
        .re    (re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (rd_q)
    );

    assign data = (rd_strobe && (clearing || !abort_q)) ? (clearing ? '1 : rd_q) : 'z;

endmodule

// File: tb/tb_vg8020_ram.sv
// Self-checking bench for vg8020_ram: directed bus cycles plus randomized writes/reads
// against an associative-array memory model. The data bus is pulled up, so a released bus reads 8'hFF.
module tb_vg8020_ram;

    logic        nclk = 1'b0;
    logic        reset, nmreq, nmreqd, nrdd, nrfshd, nsltsl3;
    logic [15:0] addr;
    tri1  [7:0]  data;
    logic [7:0]  drv_val;
    logic        drv_en;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [7:0]  model [bit [15:0]];
    bit   [15:0] written [$];

    assign data = drv_en ? drv_val : 8'hzz;

    always #5 nclk = ~nclk;

    vg8020_ram dut (
        .nclk    (nclk),
        .reset   (reset),
        .nmreq   (nmreq),
        .nmreqd  (nmreqd),
        .nrdd    (nrdd),
        .nrfshd  (nrfshd),
        .nsltsl3 (nsltsl3),
        .addr    (addr),
        .data    (data)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge nclk);
        #1;
    endtask

    task automatic idle_bus();
        nmreq   = 1'b1;
        nmreqd  = 1'b1;
        nrdd    = 1'b1;
        nrfshd  = 1'b1;
        nsltsl3 = 1'b1;
        drv_en  = 1'b0;
    endtask

    // sl is the nsltsl3 level used for the cycle (1 = another slot).
    task automatic bus_write(input logic [15:0] a, input logic [7:0] v, input logic sl);
        addr = a;
        nmreq = 1'b0;
        edge1();
        nmreqd  = 1'b0;
        nsltsl3 = sl;
        drv_val = v;
        drv_en  = 1'b1;
        edge1();
        edge1();
        @(negedge nclk);
        check("wr_bus_undriven", data, v);
        idle_bus();
        edge1();
        edge1();
        if (!sl) begin
            if (!model.exists(a)) written.push_back(a);
            model[a] = v;
        end
    endtask

    task automatic bus_read(input logic [15:0] a, input logic sl, input logic [7:0] exp,
                            input string tag);
        addr = a;
        nmreq = 1'b0;
        edge1();
        nmreqd  = 1'b0;
        nsltsl3 = sl;
        nrdd    = 1'b1;
        @(negedge nclk);
        check({tag, "_pre_rd"}, data, 8'hFF);
        edge1();
        nrdd = 1'b0;
        edge1();
        @(negedge nclk);
        check(tag, data, sl ? 8'hFF : exp);
        idle_bus();
        #1;
        check({tag, "_released"}, data, 8'hFF);
        edge1();
        edge1();
    endtask

    task automatic refresh_cycle(input logic [15:0] a);
        addr    = a;
        nmreq   = 1'b0;
        nmreqd  = 1'b0;
        nsltsl3 = 1'b0;
        nrfshd  = 1'b0;
        nrdd    = 1'b1;
        edge1();
        edge1();
        edge1();
        @(negedge nclk);
        check("refresh_undriven", data, 8'hFF);
        idle_bus();
        edge1();
        edge1();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  v;
        logic        sl;

        idle_bus();
        addr    = '0;
        drv_val = '0;
        reset   = 1'b1;
        edge1();
        edge1();
        // Strobes asserted while reset is held must not drive the bus.
        nmreqd  = 1'b0;
        nsltsl3 = 1'b0;
        nrdd    = 1'b0;
        edge1();
        @(negedge nclk);
        check("reset_bus_released", data, 8'hFF);
        idle_bus();
        edge1();
        reset = 1'b0;
        edge1();
        @(negedge nclk);
        check("idle_bus_released", data, 8'hFF);

`ifdef RAM_CLEAR_EN
        bus_read(16'h1234, 1'b0, 8'hFF, "clear_reads_ff");
        repeat (65536) edge1();
        bus_read(16'($urandom), 1'b0, 8'h00, "clear_done_zero");
`endif

        bus_write(16'h1234, 8'h42, 1'b0);
        bus_read(16'h1234, 1'b0, model[16'h1234], "read_1234");

        refresh_cycle(16'h1234);
        bus_read(16'h1234, 1'b0, model[16'h1234], "after_refresh");

        bus_write(16'h1234, 8'h55, 1'b1);
        bus_read(16'h1234, 1'b0, model[16'h1234], "after_unselected_wr");
        bus_read(16'h1234, 1'b1, 8'hFF, "unselected_read");

        bus_write(16'hFFFF, 8'hA5, 1'b0);
        bus_write(16'h0000, 8'h5A, 1'b0);
        bus_read(16'hFFFF, 1'b0, model[16'hFFFF], "read_ffff");
        bus_read(16'h0000, 1'b0, model[16'h0000], "read_0000");

        for (int i = 0; i < 24; i++) begin
            a  = 16'($urandom);
            v  = 8'($urandom);
            sl = ($urandom_range(0, 3) == 0);
            bus_write(a, v, sl);
            if ($urandom_range(0, 3) == 0) refresh_cycle(16'($urandom));
        end
        foreach (written[i]) begin
            bus_read(written[i], 1'b0, model[written[i]], "rand_read");
        end

        // Reset in the middle of a read: bus released and the cycle not resumed.
        addr  = 16'h1234;
        nmreq = 1'b0;
        edge1();
        nmreqd  = 1'b0;
        nsltsl3 = 1'b0;
        edge1();
        nrdd = 1'b0;
        edge1();
        @(negedge nclk);
        check("pre_reset_read", data, model[16'h1234]);
        reset = 1'b1;
        edge1();
        @(negedge nclk);
        check("reset_mid_read_released", data, 8'hFF);
        reset = 1'b0;
        edge1();
        @(negedge nclk);
        check("aborted_cycle_released", data, 8'hFF);
        idle_bus();
        edge1();
        edge1();
`ifndef RAM_CLEAR_EN
        bus_read(16'h1234, 1'b0, model[16'h1234], "preserved_over_reset");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
